// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_pkg
// Brief    : Shared op codes, FSM state encoding and stack bound defaults
// Revision : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    localparam logic [15:0] SP_TOP_DEF    = 16'h01FF;
    localparam logic [15:0] SP_BOTTOM_DEF = 16'h0100;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH_WR = 3'd1,
        S_POP_INC = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_CAPT = 3'd4,
        S_ERR     = 3'd5,
        S_RESP    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/stack_bounds.sv
`default_nettype none
// ============================================================================
// Module   : stack_bounds
// Brief    : Combinational full/empty/occupancy of a downward-growing stack
// Revision : 1.0 - initial release
// ============================================================================
module stack_bounds
    import stack_pkg::*;
#(
    parameter int            AW        = 16,
    parameter logic [AW-1:0] SP_TOP    = AW'(SP_TOP_DEF),
    parameter logic [AW-1:0] SP_BOTTOM = AW'(SP_BOTTOM_DEF)
) (
    input  logic [AW-1:0] sp_val,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] depth
);

    localparam logic [AW-1:0] c_one = AW'(1);

    // SP points at the next free slot, so a full stack sits one below the bottom
    assign full  = (sp_val == (SP_BOTTOM - c_one));
    assign empty = (sp_val == SP_TOP);
    assign depth = SP_TOP - sp_val;

endmodule
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stack_ctrl
// Brief    : PUSH/POP/PEEK sequencer driving SP inc/dec and the stack RAM port
// Revision : 1.0 - initial release
// ============================================================================
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int            DW        = 16,
    parameter int            AW        = 16,
    parameter logic [AW-1:0] SP_TOP    = AW'(SP_TOP_DEF),
    parameter logic [AW-1:0] SP_BOTTOM = AW'(SP_BOTTOM_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          cmd_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    input  logic [AW-1:0] sp_val,
    output logic          sp_inc,
    output logic          sp_dec,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          clr_err,
    output logic          ovf_flag,
    output logic          unf_flag,
    output logic [AW-1:0] depth
);

    localparam logic [AW-1:0] c_one = AW'(1);

    state_t        r_state;
    logic [1:0]    r_op;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_err;
    logic          r_ovf;
    logic          r_unf;
    logic          w_full;
    logic          w_empty;

    stack_bounds #(
        .AW        (AW),
        .SP_TOP    (SP_TOP),
        .SP_BOTTOM (SP_BOTTOM)
    ) u_bounds (
        .sp_val (sp_val),
        .full   (w_full),
        .empty  (w_empty),
        .depth  (depth)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NOP;
            r_data     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            // Clear first so a same-cycle flag set below takes priority
            if (clr_err) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op;
                        r_data     <= cmd_data;
                        r_rsp_data <= '0;
                        case (cmd_op)
                            OP_PUSH: begin
                                r_state   <= w_full ? S_ERR : S_PUSH_WR;
                                r_rsp_err <= w_full;
                            end
                            OP_POP: begin
                                r_state   <= w_empty ? S_ERR : S_POP_INC;
                                r_rsp_err <= w_empty;
                            end
                            OP_PEEK: begin
                                r_state   <= w_empty ? S_ERR : S_RD_ADDR;
                                r_rsp_err <= w_empty;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_PUSH_WR: r_state <= S_RESP;
                S_POP_INC: r_state <= S_RD_ADDR;
                S_RD_ADDR: r_state <= S_RD_CAPT;
                S_RD_CAPT: begin
                    r_rsp_data <= mem_rdata;
                    r_state    <= S_RESP;
                end
                S_ERR: begin
                    if (r_op == OP_PUSH) r_ovf <= 1'b1;
                    else                 r_unf <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_err <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All strobes decode straight from the state register
    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign sp_inc    = (r_state == S_POP_INC);
    assign sp_dec    = (r_state == S_PUSH_WR);
    assign mem_we    = (r_state == S_PUSH_WR);
    assign mem_re    = (r_state == S_RD_ADDR);
    assign mem_wdata = r_data;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign ovf_flag  = r_ovf;
    assign unf_flag  = r_unf;

    // PEEK reads the top entry without moving SP, so it looks one above it
    always_comb begin
        mem_addr = '0;
        if (r_state == S_PUSH_WR) begin
            mem_addr = sp_val;
        end else if (r_state == S_RD_ADDR) begin
            mem_addr = (r_op == OP_PEEK) ? (sp_val + c_one) : sp_val;
        end
    end

endmodule
`default_nettype wire
